// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, default widths
// and the fetch queue entry layout.
package instr_fetch_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs for decode.
// Flush clears the queue and wins over a push in the same cycle.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads the PC, fetches over a req/ack handshake,
// queues results for decode and drives sequential or redirect PC writes.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cnt,
  output logic              pc_wr,
  output logic [ADDR_W-1:0] pc_data,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic              req_next;
  logic [ADDR_W-1:0] addr_next;
  logic              pc_wr_next;
  logic [ADDR_W-1:0] pc_data_next;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic              has_room;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign has_room         = (count != CNT_W'(DEPTH));
  assign instr_valid      = (count != '0);
  assign pop              = instr_valid && instr_ready;
  assign push_entry.pc    = imem_addr;
  assign push_entry.instr = imem_rdata;
  assign instr_data       = head.instr;
  assign instr_pc         = head.pc;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redir_valid),
    .count     (count),
    .head      (head)
  );

  // Requests wait for a settled PC (no pending write) so pc_cnt is never stale.
  always_comb begin
    state_next   = state;
    req_next     = imem_req;
    addr_next    = imem_addr;
    pc_wr_next   = 1'b0;
    pc_data_next = pc_data;
    push         = 1'b0;
    unique case (state)
      IDLE: begin
        if (has_room && !pc_wr && !redir_valid) begin
          req_next   = 1'b1;
          addr_next  = pc_cnt;
          state_next = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          req_next   = 1'b0;
          state_next = IDLE;
          if (!redir_valid) begin
            push         = 1'b1;
            pc_wr_next   = 1'b1;
            pc_data_next = imem_addr + ADDR_W'(1);
          end
        end else if (redir_valid) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redir_valid) begin
      pc_wr_next   = 1'b1;
      pc_data_next = redir_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      pc_wr     <= 1'b0;
      pc_data   <= '0;
    end else begin
      state     <= state_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
      pc_wr     <= pc_wr_next;
      pc_data   <= pc_data_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: PC and memory models, cycle tables,
// directed corner sequences and a randomized stream check.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_cnt = '0;
  logic        pc_wr;
  logic [15:0] pc_data;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redir_valid = 1'b0;
  logic [15:0] redir_target = '0;

  int errors = 0;
  int checks = 0;
  int mem_lat = 0;
  int busy = 0;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_pc_wr;
    logic [15:0] exp_pc_data;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  instr_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_cnt       (pc_cnt),
    .pc_wr        (pc_wr),
    .pc_data      (pc_data),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .redir_valid  (redir_valid),
    .redir_target (redir_target)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: PC register and memory respond mid-cycle, outputs sampled 1ns after the edge.
  task automatic apply_stimulus();
    @(negedge clk);
    if (pc_wr) pc_cnt = pc_data;
    if (imem_req) begin
      if (busy >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ 16'hA5A5;
        busy       = 0;
      end else begin
        imem_ack = 1'b0;
        busy++;
      end
    end else begin
      imem_ack = 1'b0;
      busy     = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_pc_wr"}, pc_wr, 1'b0);
    check_word({tag, "_pc_data"}, pc_data, 16'h0000);
    check_bit({tag, "_imem_req"}, imem_req, 1'b0);
    check_word({tag, "_imem_addr"}, imem_addr, 16'h0000);
    check_bit({tag, "_instr_valid"}, instr_valid, 1'b0);
    check_word({tag, "_instr_data"}, instr_data, 16'h0000);
    check_word({tag, "_instr_pc"}, instr_pc, 16'h0000);
  endtask

  task automatic apply_reset(input logic [15:0] init);
    rst          = 1'b0;
    pc_cnt       = init;
    imem_ack     = 1'b0;
    busy         = 0;
    mem_lat      = 0;
    instr_ready  = 1'b0;
    redir_valid  = 1'b0;
    redir_target = '0;
    apply_stimulus();
    apply_stimulus();
    check_all_zero("reset");
    rst = 1'b1;
  endtask

  task automatic wait_req(input string name, input int max_cycles);
    int n = 0;
    while (!imem_req && n < max_cycles) begin
      apply_stimulus();
      n++;
    end
    check_bit({name, "_req_timeout"}, imem_req, 1'b1);
  endtask

  initial begin
    logic [15:0] exp_pc;
    int          fetches;
    int          deliveries;
    int          n;

    vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h0000, 16'hA5A5};
    vecs[2] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'h0001, 1'b1, 16'h0002, 1'b1, 16'h0001, 16'hA5A4};
    vecs[5] = '{1'b1, 1'b0, 16'h0001, 1'b0, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h0002, 1'b1, 16'h0003, 1'b1, 16'h0002, 16'hA5A7};

    // Free run from 0x0000 with a 1-cycle memory, cycle by cycle.
    apply_reset(16'h0000);
    for (int i = 0; i < 8; i++) begin
      instr_ready = vecs[i].ready;
      apply_stimulus();
      check_bit($sformatf("run%0d_req", i), imem_req, vecs[i].exp_req);
      check_word($sformatf("run%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check_bit($sformatf("run%0d_pc_wr", i), pc_wr, vecs[i].exp_pc_wr);
      check_word($sformatf("run%0d_pc_data", i), pc_data, vecs[i].exp_pc_data);
      check_bit($sformatf("run%0d_valid", i), instr_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check_word($sformatf("run%0d_instr_pc", i), instr_pc, vecs[i].exp_pc);
        check_word($sformatf("run%0d_instr_data", i), instr_data, vecs[i].exp_data);
      end
    end

    // Backpressure: two fetches fill the queue, then fetching stalls.
    apply_reset(16'h0000);
    fetches = 0;
    for (int i = 0; i < 15; i++) begin
      apply_stimulus();
      if (pc_wr) fetches++;
    end
    check_word("bp_fetch_count", 16'(fetches), 16'd2);
    check_bit("bp_req_stalled", imem_req, 1'b0);
    check_bit("bp_valid", instr_valid, 1'b1);
    check_word("bp_head0_pc", instr_pc, 16'h0000);
    instr_ready = 1'b1;
    apply_stimulus();
    check_bit("bp_valid1", instr_valid, 1'b1);
    check_word("bp_head1_pc", instr_pc, 16'h0001);
    check_word("bp_head1_data", instr_data, 16'hA5A4);
    apply_stimulus();
    wait_req("bp_resume", 10);
    check_word("bp_resume_addr", imem_addr, 16'h0002);

    // Redirect while a slow request is outstanding.
    apply_reset(16'h0000);
    instr_ready = 1'b1;
    mem_lat     = 3;
    apply_stimulus();
    check_bit("drain_req_issued", imem_req, 1'b1);
    redir_valid  = 1'b1;
    redir_target = 16'h0100;
    apply_stimulus();
    redir_valid = 1'b0;
    check_bit("drain_pc_wr", pc_wr, 1'b1);
    check_word("drain_pc_data", pc_data, 16'h0100);
    check_bit("drain_req_held", imem_req, 1'b1);
    n = 0;
    while (imem_req && n < 10) begin
      apply_stimulus();
      check_bit("drain_no_pc_wr", pc_wr, 1'b0);
      check_bit("drain_queue_empty", instr_valid, 1'b0);
      n++;
    end
    check_bit("drain_req_dropped", imem_req, 1'b0);
    mem_lat = 0;
    wait_req("drain_refetch", 10);
    check_word("drain_refetch_addr", imem_addr, 16'h0100);

    // Redirect in the same cycle as the ack.
    apply_reset(16'h0010);
    instr_ready = 1'b1;
    apply_stimulus();
    check_word("coinc_addr", imem_addr, 16'h0010);
    redir_valid  = 1'b1;
    redir_target = 16'h0200;
    apply_stimulus();
    redir_valid = 1'b0;
    check_bit("coinc_pc_wr", pc_wr, 1'b1);
    check_word("coinc_pc_data", pc_data, 16'h0200);
    check_bit("coinc_no_push", instr_valid, 1'b0);
    check_bit("coinc_req_low", imem_req, 1'b0);
    apply_stimulus();
    check_bit("coinc_single_pc_wr", pc_wr, 1'b0);
    check_word("coinc_pc_data_kept", pc_data, 16'h0200);
    wait_req("coinc_refetch", 10);
    check_word("coinc_refetch_addr", imem_addr, 16'h0200);

    // PC wrap-around at the top of the address space.
    apply_reset(16'hFFFF);
    instr_ready = 1'b0;
    apply_stimulus();
    check_word("wrap_addr", imem_addr, 16'hFFFF);
    apply_stimulus();
    check_bit("wrap_pc_wr", pc_wr, 1'b1);
    check_word("wrap_pc_data", pc_data, 16'h0000);
    check_word("wrap_instr_pc", instr_pc, 16'hFFFF);
    check_word("wrap_instr_data", instr_data, 16'h5A5A);
    wait_req("wrap_next", 10);
    check_word("wrap_next_addr", imem_addr, 16'h0000);

    // Asynchronous reset while a request is outstanding over a filling queue.
    apply_reset(16'h0000);
    apply_stimulus();
    apply_stimulus();
    check_bit("areset_first_push", instr_valid, 1'b1);
    mem_lat = 10;
    wait_req("areset_second", 10);
    apply_stimulus();
    check_bit("areset_req_pending", imem_req, 1'b1);
    rst = 1'b0;
    #1;
    check_all_zero("areset");
    pc_cnt = 16'h0040;
    apply_stimulus();
    rst     = 1'b1;
    mem_lat = 0;
    wait_req("areset_restart", 10);
    check_word("areset_restart_addr", imem_addr, 16'h0040);

    // Randomized traffic checked against the expected instruction stream.
    exp_pc = 16'($urandom);
    apply_reset(exp_pc);
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready  = ($urandom_range(0, 9) < 7);
      redir_valid  = ($urandom_range(0, 39) == 0);
      redir_target = 16'($urandom);
      if (!imem_req) mem_lat = $urandom_range(0, 3);
      if (instr_valid && instr_ready) begin
        check_word("rand_instr_pc", instr_pc, exp_pc);
        check_word("rand_instr_data", instr_data, exp_pc ^ 16'hA5A5);
        exp_pc = exp_pc + 16'd1;
        deliveries++;
      end
      if (redir_valid) exp_pc = redir_target;
      apply_stimulus();
    end
    redir_valid = 1'b0;
    instr_ready = 1'b0;
    check_bit("rand_progress", deliveries >= 200, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
